// File: rtl/mm_tmr_pkg.sv
// Shared definitions for the mm_tmr memory-mapped timer: register offsets,
// CTRL bit positions, default base address and the CTRL read-word packer.
package mm_tmr_pkg;

   localparam logic [15:0] TMR_BASE_ADDR = 16'hC008;

   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_PSC    = 2'd1;
   localparam logic [1:0] TMR_RELOAD = 2'd2;
   localparam logic [1:0] TMR_COUNT  = 2'd3;

   localparam int TMR_EN_BIT  = 0;
   localparam int TMR_PER_BIT = 1;
   localparam int TMR_OV_BIT  = 2;

   function automatic logic [15:0] tmr_ctrl_word(input logic en, input logic per,
                                                 input logic ov);
      logic [15:0] w;
      w = '0;
      w[TMR_EN_BIT]  = en;
      w[TMR_PER_BIT] = per;
      w[TMR_OV_BIT]  = ov;
      return w;
   endfunction

endpackage

// File: rtl/mm_tmr_if.sv
// CPU memory-mapped bus as seen by the timer; read data is a private
// return path that the top level ORs into the shared read bus.
interface mm_tmr_if;
   logic [15:0] mm_addr;
   logic        mm_we;
   logic        mm_re;
   logic [15:0] mm_wdata;
   logic [15:0] tmr_rdata;

   modport master (
      output mm_addr, mm_we, mm_re, mm_wdata,
      input  tmr_rdata
   );

   modport slave (
      input  mm_addr, mm_we, mm_re, mm_wdata,
      output tmr_rdata
   );
endinterface

// File: rtl/mm_tmr_prescaler.sv
// tmr_prescaler: free-running compare counter producing one tick every PSC+1
// enabled cycles; a start pulse restarts the count from zero.
module tmr_prescaler #(
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             start,
   input  logic [PSC_W-1:0] psc,
   output logic             tick
);

   localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

   logic [PSC_W-1:0] psc_cnt;
   logic             match;

   assign match = (psc_cnt == psc);
   assign tick  = run & match;

   // A counter already past a newly written PSC wraps through 2^PSC_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_cnt <= '0;
      end else if (start) begin
         psc_cnt <= '0;
      end else if (run) begin
         psc_cnt <= match ? '0 : psc_cnt + PSC_ONE;
      end
   end

endmodule

// File: rtl/mm_tmr.sv
// mm_tmr: memory-mapped down-counting timer with sticky OV flag and a one-cycle
// tmr_ov interrupt pulse. Prescaler present only when MM_TMR_PRESCALE_EN is defined.
module mm_tmr
   import mm_tmr_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = TMR_BASE_ADDR,
   parameter int          PSC_W     = 8
) (
   input  logic    clk,
   input  logic    rst_n,
   mm_tmr_if.slave bus,
   output logic    tmr_ov
);

   logic             hit;
   logic [1:0]       off;
   logic             wr;
   logic             ctrl_wr;
   logic             stop_wr;
   logic             start_wr;
   logic             run;
   logic             tick;
   logic             ov_evt;

   logic             en_q;
   logic             per_q;
   logic             ov_q;
   logic [PSC_W-1:0] psc_q;
   logic [15:0]      reload_q;
   logic [15:0]      count_q;
   logic             tmr_ov_q;

   assign off      = bus.mm_addr[1:0];
   assign hit      = (bus.mm_addr[15:2] == BASE_ADDR[15:2]);
   assign wr       = bus.mm_we & hit;
   assign ctrl_wr  = wr & (off == TMR_CTRL);
   assign stop_wr  = ctrl_wr & ~bus.mm_wdata[TMR_EN_BIT];
   assign start_wr = ctrl_wr & bus.mm_wdata[TMR_EN_BIT] & ~en_q;

   // A write clearing EN beats any tick in the same cycle, so count and prescaler freeze.
   assign run      = en_q & ~stop_wr;
   assign ov_evt   = tick & (count_q == 16'd0);

`ifdef MM_TMR_PRESCALE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q <= '0;
      end else if (wr && (off == TMR_PSC)) begin
         psc_q <= bus.mm_wdata[PSC_W-1:0];
      end
   end

   tmr_prescaler #(
      .PSC_W (PSC_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .start (start_wr),
      .psc   (psc_q),
      .tick  (tick)
   );
`else
   assign psc_q = '0;
   assign tick  = run;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q     <= 1'b0;
         per_q    <= 1'b0;
         ov_q     <= 1'b0;
         reload_q <= 16'hFFFF;
         count_q  <= 16'd0;
         tmr_ov_q <= 1'b0;
      end else begin
         tmr_ov_q <= ov_evt;

         if (ctrl_wr) begin
            en_q  <= bus.mm_wdata[TMR_EN_BIT];
            per_q <= bus.mm_wdata[TMR_PER_BIT];
         end
         if (ov_evt && !per_q) begin
            en_q <= 1'b0;
         end

         // Overflow outranks a simultaneous write-1-to-clear of OV.
         if (ov_evt) begin
            ov_q <= 1'b1;
         end else if (ctrl_wr && bus.mm_wdata[TMR_OV_BIT]) begin
            ov_q <= 1'b0;
         end

         if (wr && (off == TMR_RELOAD)) begin
            reload_q <= bus.mm_wdata;
         end

         if (start_wr) begin
            count_q <= reload_q;
         end else if (tick) begin
            if (count_q != 16'd0) begin
               count_q <= count_q - 16'd1;
            end else if (per_q) begin
               count_q <= reload_q;
            end
         end
      end
   end

   assign tmr_ov = tmr_ov_q;

   always_comb begin
      bus.tmr_rdata = 16'h0000;
      if (bus.mm_re && hit) begin
         case (off)
            TMR_CTRL:   bus.tmr_rdata = tmr_ctrl_word(en_q, per_q, ov_q);
            TMR_PSC:    bus.tmr_rdata = 16'(psc_q);
            TMR_RELOAD: bus.tmr_rdata = reload_q;
            default:    bus.tmr_rdata = count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_tmr.sv
// Directed testbench for mm_tmr; exercises the prescaler scenarios when
// MM_TMR_PRESCALE_EN is defined and the bypassed path otherwise.
module tb_mm_tmr;

   localparam logic [15:0] A_CTRL = 16'hC008;
   localparam logic [15:0] A_PSC  = 16'hC009;
   localparam logic [15:0] A_REL  = 16'hC00A;
   localparam logic [15:0] A_CNT  = 16'hC00B;

   logic clk;
   logic rst_n;
   logic tmr_ov;
   int   total;
   int   bad;

   mm_tmr_if bus ();

   mm_tmr #(
      .BASE_ADDR (16'hC008),
      .PSC_W     (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .tmr_ov (tmr_ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; the write lands on the next posedge and returns at the following negedge.
   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      bus.mm_addr  = a;
      bus.mm_wdata = d;
      bus.mm_we    = 1'b1;
      @(negedge clk);
      bus.mm_we    = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
      bus.mm_addr = a;
      bus.mm_re   = 1'b1;
      #1;
      d = bus.tmr_rdata;
      bus.mm_re   = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] d;
      total++;
      if (tmr_ov !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b want=0", tmr_ov); end
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL reset_ctrl got=%h want=0000", d); end
      bus_read(A_PSC, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL reset_psc got=%h want=0000", d); end
      bus_read(A_REL, d);
      total++;
      if (d !== 16'hFFFF) begin bad++; $display("FAIL reset_reload got=%h want=ffff", d); end
      bus_read(A_CNT, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h want=0000", d); end
      bus.mm_addr = A_REL;
      #1;
      total++;
      if (bus.tmr_rdata !== 16'h0000) begin
         bad++; $display("FAIL rdata_no_re got=%h want=0000", bus.tmr_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_decode;
      logic [15:0] d;
      bus_read(16'hC00C, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL decode_base_p4 got=%h want=0000", d); end
      bus_read(16'hC007, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL decode_base_m1 got=%h want=0000", d); end
      bus_write(16'hC00E, 16'h0000);
      bus_read(A_REL, d);
      total++;
      if (d !== 16'hFFFF) begin bad++; $display("FAIL decode_alias_wr got=%h want=ffff", d); end
   endtask

   task automatic test_oneshot;
      logic [15:0] d;
      bus_write(A_PSC, 16'h0000);
      bus_write(A_REL, 16'h0002);
      bus_write(A_CTRL, 16'h0001);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         total++;
         if (tmr_ov !== (k == 3)) begin
            bad++; $display("FAIL oneshot_ov cyc=%0d got=%b want=%b", k, tmr_ov, (k == 3));
         end
      end
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0004) begin bad++; $display("FAIL oneshot_ctrl got=%h want=0004", d); end
      bus_read(A_CNT, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL oneshot_count got=%h want=0000", d); end
   endtask

   task automatic test_count_read;
      logic [15:0] d;
      logic [15:0] exp_cnt [3] = '{16'd5, 16'd4, 16'd3};
      bus_write(A_REL, 16'h0005);
      bus_write(A_CTRL, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         bus_read(A_CNT, d);
         total++;
         if (d !== exp_cnt[k]) begin
            bad++; $display("FAIL count_run idx=%0d got=%h want=%h", k, d, exp_cnt[k]);
         end
         if (k < 2) @(negedge clk);
      end
      bus_write(A_CNT, 16'h1234);
      bus_read(A_CNT, d);
      total++;
      if (d !== 16'h0002) begin bad++; $display("FAIL count_wr_ignored got=%h want=0002", d); end
      repeat (5) @(negedge clk);
      bus_write(A_CTRL, 16'h0004);
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL count_clear_ov got=%h want=0000", d); end
   endtask

   task automatic test_ov_race;
      logic [15:0] d;
      bus_write(A_PSC, 16'h0000);
      bus_write(A_REL, 16'h0002);
      bus_write(A_CTRL, 16'h0003);
      repeat (5) @(negedge clk);
      bus_write(A_CTRL, 16'h0007);
      total++;
      if (tmr_ov !== 1'b1) begin bad++; $display("FAIL race_ov_pulse got=%b want=1", tmr_ov); end
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0007) begin bad++; $display("FAIL race_ov_kept got=%h want=0007", d); end
      bus_write(A_CTRL, 16'h0007);
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0003) begin bad++; $display("FAIL race_ov_cleared got=%h want=0003", d); end
      bus_write(A_CTRL, 16'h0000);
      bus_read(A_CNT, d);
      total++;
      if (d !== 16'h0001) begin bad++; $display("FAIL stop_count got=%h want=0001", d); end
      repeat (3) @(negedge clk);
      bus_read(A_CNT, d);
      total++;
      if (d !== 16'h0001) begin bad++; $display("FAIL stop_frozen got=%h want=0001", d); end
   endtask

   task automatic test_stop_race;
      logic [15:0] d;
      bus_write(A_REL, 16'h0002);
      bus_write(A_CTRL, 16'h0001);
      repeat (2) @(negedge clk);
      bus_write(A_CTRL, 16'h0000);
      total++;
      if (tmr_ov !== 1'b0) begin bad++; $display("FAIL stoprace_ov got=%b want=0", tmr_ov); end
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL stoprace_ctrl got=%h want=0000", d); end
      bus_read(A_CNT, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL stoprace_count got=%h want=0000", d); end
      @(negedge clk);
      total++;
      if (tmr_ov !== 1'b0) begin bad++; $display("FAIL stoprace_late_ov got=%b want=0", tmr_ov); end
   endtask

   task automatic test_periodic;
      logic [15:0] d;
`ifdef MM_TMR_PRESCALE_EN
      bus_write(A_PSC, 16'h0003);
      bus_write(A_REL, 16'h0004);
      bus_write(A_CTRL, 16'h0003);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         total++;
         if (tmr_ov !== (k % 20 == 0)) begin
            bad++; $display("FAIL periodic_psc cyc=%0d got=%b want=%b", k, tmr_ov, (k % 20 == 0));
         end
      end
`else
      bus_write(A_REL, 16'h0009);
      bus_write(A_CTRL, 16'h0003);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         total++;
         if (tmr_ov !== (k % 10 == 0)) begin
            bad++; $display("FAIL periodic cyc=%0d got=%b want=%b", k, tmr_ov, (k % 10 == 0));
         end
      end
`endif
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0007) begin bad++; $display("FAIL periodic_ctrl got=%h want=0007", d); end
      bus_write(A_CTRL, 16'h0004);
      bus_write(A_PSC, 16'h00FF);
      bus_read(A_PSC, d);
      total++;
`ifdef MM_TMR_PRESCALE_EN
      if (d !== 16'h00FF) begin bad++; $display("FAIL psc_readback got=%h want=00ff", d); end
`else
      if (d !== 16'h0000) begin bad++; $display("FAIL psc_readback got=%h want=0000", d); end
`endif
   endtask

   task automatic test_reset_mid;
      logic [15:0] d;
      bus_write(A_PSC, 16'h0000);
      bus_write(A_REL, 16'h0009);
      bus_write(A_CTRL, 16'h0003);
      repeat (10) @(negedge clk);
      total++;
      if (tmr_ov !== 1'b1) begin bad++; $display("FAIL mid_ov_before got=%b want=1", tmr_ov); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (tmr_ov !== 1'b0) begin bad++; $display("FAIL mid_ov_async got=%b want=0", tmr_ov); end
      bus_read(A_CTRL, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL mid_ctrl got=%h want=0000", d); end
      bus_read(A_REL, d);
      total++;
      if (d !== 16'hFFFF) begin bad++; $display("FAIL mid_reload got=%h want=ffff", d); end
      bus_read(A_CNT, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL mid_count got=%h want=0000", d); end
      bus_read(A_PSC, d);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL mid_psc got=%h want=0000", d); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      bus.mm_addr  = 16'h0000;
      bus.mm_we    = 1'b0;
      bus.mm_re    = 1'b0;
      bus.mm_wdata = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      test_reset();
      test_decode();
      test_oneshot();
      test_count_read();
      test_ov_race();
      test_stop_race();
      test_periodic();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mm_tmr.md
# mm_tmr

Memory-mapped down-counting timer that responds to CPU bus accesses on `mm_addr`/`mm_we`/`mm_re`/`mm_wdata`. It is an interrupt source: its one-cycle `tmr_ov` pulse feeds bit 1 of the interrupt controller's `int_src` vector. Read data returns on a private bus that is zero when the block is not selected, so the top level can OR it into the shared `mm_rdata`.

## Interface
- `BASE_ADDR`, default 16'hC008: word address of register 0. The block decodes four consecutive words.
- `PSC_W`, default 8: prescaler width in bits, at most 16.
- `clk` input, 1: system clock, rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `mm_addr` input, 16: CPU memory-mapped address.
- `mm_we` input, 1: write strobe. Sampled at posedge.
- `mm_re` input, 1: read strobe.
- `mm_wdata` input, 16: write data.
- `tmr_rdata` output, 16: read data. Combinational. 16'h0000 unless `mm_re` is high and the address hits.
- `tmr_ov` output, 1: registered overflow pulse to the interrupt controller.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 OV (sticky; write 1 to clear), bits 15:3 read 0.
  - 1 PSC: prescale value, `PSC_W` bits, zero-extended on read.
  - 2 RELOAD: 16 bits.
  - 3 COUNT: read-only current count. Writes to COUNT are ignored.
- A hit is `mm_addr[15:2] == BASE_ADDR[15:2]`. A write occurs when `mm_we` is high and the address hits; it updates the register at that posedge.
- Prescaler:
  - `psc_cnt` runs only while EN is 1.
  - `tick` asserts when `psc_cnt == PSC`, and `psc_cnt` then returns to 0.
  - One tick occurs every PSC+1 cycles.
- Counter behaviour on a tick:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: overflow event.
- Overflow event:
  - `tmr_ov` pulses, and OV is set.
  - If PERIODIC=1, COUNT reloads from RELOAD.
  - If PERIODIC=0, EN clears and COUNT stays 0.
- Start: a write that takes EN from 0 to 1 loads COUNT from RELOAD and clears `psc_cnt`.
- A write that sets EN to 0 freezes COUNT and `psc_cnt`.
- Writing RELOAD while running does not alter COUNT. The new value applies at the next reload.
- Writing PSC while running takes effect on the next compare. If `psc_cnt` is already greater than the new PSC, the prescaler counts up and wraps through 2^`PSC_W` before matching.
- Overflow period with PERIODIC=1 is (RELOAD+1)*(PSC+1) cycles. RELOAD=0 gives one overflow per tick.
- Arithmetic is unsigned. COUNT never wraps below 0.

## Timing
- Reset values: CTRL=0, PSC=0, RELOAD=16'hFFFF, COUNT=0, `psc_cnt`=0, `tmr_ov`=0. `tmr_rdata` is 0 while `mm_re` is low.
- Read latency is zero: `tmr_rdata` reflects register state in the same cycle. A same-cycle write is not visible until the next cycle.
- `tmr_ov` is high for exactly one cycle, the cycle after the posedge at which the terminal tick is sampled. OV reads 1 from that same cycle.
- Simultaneous overflow and an OV-clear write: the overflow wins and OV remains 1.
- Simultaneous terminal tick and a CTRL write clearing EN: the write wins. No overflow occurs and COUNT holds 0.
- A read and a write to the same register in one cycle return the old value.
- If `rst_n` falls mid-count, all state clears immediately and `tmr_ov` drops asynchronously.

## Configuration
- `MM_TMR_PRESCALE_EN` defined: PSC register and prescaler are present as described.
- `MM_TMR_PRESCALE_EN` undefined:
  - `tick` equals EN every cycle.
  - PSC reads 0 and writes to it are ignored.
  - Period is RELOAD+1 cycles.

## Structure
- The shared package `mm_tmr_pkg` holds:
  - Register offsets: `TMR_CTRL`=0, `TMR_PSC`=1, `TMR_RELOAD`=2, `TMR_COUNT`=3.
  - CTRL bit indices: `TMR_EN_BIT`, `TMR_PER_BIT`, `TMR_OV_BIT`.
  - Default `BASE_ADDR`.
- One sub-module, `tmr_prescaler`, contains `psc_cnt`, the compare, and the clear-on-start logic. It outputs `tick`. It is omitted or bypassed when the macro is undefined.
- All other logic (address decode, registers, COUNT, overflow, read mux) stays in `mm_tmr`.

## Test plan
- Reset check: assert `rst_n`=0 mid-operation → all registers read their reset values, and `tmr_ov`=0 immediately.
- Periodic timing: PSC=3, RELOAD=4, CTRL=16'h0003 → `tmr_ov` pulses exactly every 20 cycles. The first pulse is 20 cycles after the write's posedge. Each pulse is one cycle wide.
- One-shot: PSC=0, RELOAD=2, CTRL=16'h0001 → a single `tmr_ov` pulse 3 cycles later. CTRL then reads 16'h0004, and COUNT holds 0 with no further pulses.
- OV-clear race: arrange a CTRL write of 16'h0007 (clear OV) in the same cycle as a terminal tick → OV still reads 1 afterward. A later clear with no tick reads OV=0.
- Bus isolation and decode:
  - Reads at `BASE_ADDR`+4 and `BASE_ADDR`-1 → `tmr_rdata`=0.
  - Read of COUNT while running → decreasing values.
  - Write 16'h1234 to COUNT → ignored.
- Macro off: RELOAD=9, periodic → `tmr_ov` every 10 cycles. A PSC write of 16'h00FF reads back 0.
